// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and time-field limits for the alarm unit.
`default_nettype none
package alarm_pkg;

  localparam int TIME_W = 7;
  localparam logic [TIME_W-1:0] MAX_HOUR = 7'd23;
  localparam logic [TIME_W-1:0] MAX_MIN  = 7'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

endpackage
`default_nettype wire

// File: rtl/key_sync_edge.sv
// key_sync_edge: two-flop synchroniser for an active-low key plus a one-cycle
// press pulse on the synchronised falling edge.
`default_nettype none
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      last  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      last  <= sync2;
    end
  end

  // Flops clear to 0, so the idle-high key produces a rising edge after reset, never a press.
  assign press = last & ~sync2;

endmodule
`default_nettype wire

// File: rtl/alarm_unit.sv
// alarm_unit: compares the running time against a setpoint and sequences
// ring / snooze / dismiss behaviour with a blinking LED while ringing.
`default_nettype none
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int CLK_HZ           = 50000000,
  parameter int BLINK_HZ         = 2,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [TIME_W-1:0] cur_minutes,
  input  logic [TIME_W-1:0] cur_hours,
  input  logic [TIME_W-1:0] alarm_minutes,
  input  logic [TIME_W-1:0] alarm_hours,
  input  logic              alarm_enable,
  input  logic              snooze_n,
  input  logic              dismiss_n,
  output logic              ringing,
  output logic              blink,
  output logic [1:0]        state,
  output logic [1:0]        snooze_count
);

  localparam int          HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
  localparam logic [31:0] BLINK_LAST  = 32'(HALF_PERIOD - 1);
  localparam logic [7:0]  RING_LIM    = 8'(RING_TIMEOUT_MIN);
  localparam logic [7:0]  SNZ_LIM     = 8'(SNOOZE_MIN);
  localparam logic [1:0]  SNZ_MAX     = 2'(MAX_SNOOZE);

  alarm_state_t      cur_state, nxt_state;
  logic [7:0]        ring_cnt, ring_cnt_nxt;
  logic [7:0]        snz_cnt, snz_cnt_nxt;
  logic [1:0]        snz_used, snz_used_nxt;
  logic              blink_r, blink_nxt;
  logic [31:0]       blink_cnt, blink_cnt_nxt;
  logic [TIME_W-1:0] prev_min;
  logic              primed;

  logic snooze_press;
  logic dismiss_press;
  logic minute_tick;
  logic alarm_valid;
  logic match;
  logic [7:0] ring_inc;
  logic [7:0] snz_inc;

  key_sync_edge u_snooze (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .key_n (snooze_n),
    .press (snooze_press)
  );

  key_sync_edge u_dismiss (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .key_n (dismiss_n),
    .press (dismiss_press)
  );

  // primed holds off the tick until prev_min has captured a real minute value.
  assign minute_tick = primed && (cur_minutes != prev_min);
  assign alarm_valid = (alarm_hours <= MAX_HOUR) && (alarm_minutes <= MAX_MIN);
  assign match       = minute_tick && alarm_valid &&
                       (cur_minutes == alarm_minutes) && (cur_hours == alarm_hours);
  assign ring_inc    = (ring_cnt == 8'hFF) ? ring_cnt : ring_cnt + 8'd1;
  assign snz_inc     = (snz_cnt  == 8'hFF) ? snz_cnt  : snz_cnt  + 8'd1;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= IDLE;
      ring_cnt  <= 8'd0;
      snz_cnt   <= 8'd0;
      snz_used  <= 2'd0;
      blink_r   <= 1'b0;
      blink_cnt <= 32'd0;
      prev_min  <= '0;
      primed    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      ring_cnt  <= ring_cnt_nxt;
      snz_cnt   <= snz_cnt_nxt;
      snz_used  <= snz_used_nxt;
      blink_r   <= blink_nxt;
      blink_cnt <= blink_cnt_nxt;
      prev_min  <= cur_minutes;
      primed    <= 1'b1;
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    ring_cnt_nxt  = ring_cnt;
    snz_cnt_nxt   = snz_cnt;
    snz_used_nxt  = snz_used;
    blink_nxt     = blink_r;
    blink_cnt_nxt = blink_cnt;

    case (cur_state)
      IDLE: begin
        if (alarm_enable) nxt_state = ARMED;
      end
      ARMED: begin
        if (match) begin
          nxt_state     = RINGING;
          snz_used_nxt  = 2'd0;
          ring_cnt_nxt  = 8'd0;
          blink_nxt     = 1'b1;
          blink_cnt_nxt = 32'd0;
        end
      end
      RINGING: begin
        if (blink_cnt == BLINK_LAST) begin
          blink_nxt     = ~blink_r;
          blink_cnt_nxt = 32'd0;
        end else begin
          blink_cnt_nxt = blink_cnt + 32'd1;
        end
        if (dismiss_press) begin
          nxt_state = ARMED;
        end else if (minute_tick && (ring_inc >= RING_LIM)) begin
          nxt_state = ARMED;
        end else if (snooze_press && (snz_used < SNZ_MAX)) begin
          nxt_state    = SNOOZE;
          snz_used_nxt = snz_used + 2'd1;
          snz_cnt_nxt  = 8'd0;
        end else if (minute_tick) begin
          ring_cnt_nxt = ring_inc;
        end
      end
      SNOOZE: begin
        if (dismiss_press) begin
          nxt_state = ARMED;
        end else if (minute_tick) begin
          if (snz_inc >= SNZ_LIM) begin
            nxt_state     = RINGING;
            ring_cnt_nxt  = 8'd0;
            blink_nxt     = 1'b1;
            blink_cnt_nxt = 32'd0;
          end else begin
            snz_cnt_nxt = snz_inc;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase

    if (!alarm_enable) nxt_state = IDLE;

    if (nxt_state != RINGING) begin
      blink_nxt     = 1'b0;
      blink_cnt_nxt = 32'd0;
    end
  end

  assign ringing      = (cur_state == RINGING);
  assign blink        = blink_r;
  assign state        = cur_state;
  assign snooze_count = snz_used;

endmodule
`default_nettype wire

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: directed self-checking bench for alarm_unit with small
// parameters (8 Hz clock, 1 Hz blink, 2-minute snooze, 3-minute timeout).
`default_nettype none
module tb_alarm_unit;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic [6:0] cur_minutes, cur_hours, alarm_minutes, alarm_hours;
  logic       alarm_enable, snooze_n, dismiss_n;
  logic       ringing, blink;
  logic [1:0] state, snooze_count;

  int errors = 0;
  int checks = 0;

  alarm_unit #(
    .CLK_HZ(8), .BLINK_HZ(1), .SNOOZE_MIN(2), .RING_TIMEOUT_MIN(3), .MAX_SNOOZE(3)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .cur_minutes   (cur_minutes),
    .cur_hours     (cur_hours),
    .alarm_minutes (alarm_minutes),
    .alarm_hours   (alarm_hours),
    .alarm_enable  (alarm_enable),
    .snooze_n      (snooze_n),
    .dismiss_n     (dismiss_n),
    .ringing       (ringing),
    .blink         (blink),
    .state         (state),
    .snooze_count  (snooze_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_time(input int h, input int m);
    cur_hours   = 7'(h);
    cur_minutes = 7'(m);
    step(1);
  endtask

  task automatic press(input logic snz, input logic dis);
    snooze_n  = ~snz;
    dismiss_n = ~dis;
    step(3);
    snooze_n  = 1'b1;
    dismiss_n = 1'b1;
    step(3);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; alarm_enable = 1'b1; snooze_n = 1'b1; dismiss_n = 1'b1;
    cur_hours = 7'd7; cur_minutes = 7'd30; alarm_hours = 7'd7; alarm_minutes = 7'd30;
    step(3);
    checks++;
    if ({state, ringing, blink, snooze_count} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got=%b want=000000", {state, ringing, blink, snooze_count});
    end
    reset_n = 1'b1;
    step(4);
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL reset_no_first_tick state got=%0d want=1", state);
    end
  endtask

  task automatic test_ring_blink;
    set_time(7, 29);
    cur_minutes = 7'd30;
    checks++;
    if (state !== 2'd1 || ringing !== 1'b0) begin
      errors++; $display("FAIL match_cycle state got=%0d ringing=%b want=1/0", state, ringing);
    end
    step(1);
    checks++;
    if (state !== 2'd2 || ringing !== 1'b1) begin
      errors++; $display("FAIL ring_entry state got=%0d ringing=%b want=2/1", state, ringing);
    end
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) step(1);
      checks++;
      if (blink !== ((i % 8) < 4)) begin
        errors++; $display("FAIL blink_cycle%0d got=%b want=%b", i, blink, ((i % 8) < 4));
      end
    end
  endtask

  task automatic test_snooze;
    for (int k = 1; k <= 3; k++) begin
      press(1'b1, 1'b0);
      checks++;
      if (state !== 2'd3 || snooze_count !== 2'(k) || ringing !== 1'b0 || blink !== 1'b0) begin
        errors++; $display("FAIL snooze_enter%0d state=%0d cnt=%0d ring=%b blink=%b want=3/%0d/0/0",
                           k, state, snooze_count, ringing, blink, k);
      end
      set_time(7, 29 + 2 * k);
      checks++;
      if (state !== 2'd3) begin
        errors++; $display("FAIL snooze_hold%0d state got=%0d want=3", k, state);
      end
      set_time(7, 30 + 2 * k);
      checks++;
      if (state !== 2'd2 || blink !== 1'b1 || snooze_count !== 2'(k)) begin
        errors++; $display("FAIL snooze_return%0d state=%0d blink=%b cnt=%0d want=2/1/%0d",
                           k, state, blink, snooze_count, k);
      end
    end
    press(1'b1, 1'b0);
    checks++;
    if (state !== 2'd2 || snooze_count !== 2'd3) begin
      errors++; $display("FAIL snooze_limit state=%0d cnt=%0d want=2/3", state, snooze_count);
    end
    press(1'b0, 1'b1);
    checks++;
    if (state !== 2'd1 || ringing !== 1'b0) begin
      errors++; $display("FAIL dismiss state=%0d ringing=%b want=1/0", state, ringing);
    end
  endtask

  task automatic test_timeout;
    alarm_minutes = 7'd37;
    set_time(7, 37);
    checks++;
    if (state !== 2'd2 || snooze_count !== 2'd0) begin
      errors++; $display("FAIL rering state=%0d cnt=%0d want=2/0", state, snooze_count);
    end
    set_time(7, 38);
    set_time(7, 39);
    checks++;
    if (state !== 2'd2) begin
      errors++; $display("FAIL timeout_early state got=%0d want=2", state);
    end
    set_time(7, 40);
    checks++;
    if (state !== 2'd1 || ringing !== 1'b0) begin
      errors++; $display("FAIL timeout state=%0d ringing=%b want=1/0", state, ringing);
    end
    alarm_minutes = 7'd41;
    set_time(7, 41);
    press(1'b1, 1'b1);
    checks++;
    if (state !== 2'd1 || snooze_count !== 2'd0) begin
      errors++; $display("FAIL both_keys state=%0d cnt=%0d want=1/0", state, snooze_count);
    end
  endtask

  task automatic test_invalid;
    int rang;
    for (int s = 0; s < 2; s++) begin
      rang = 0;
      alarm_hours   = (s == 0) ? 7'd24 : 7'd7;
      alarm_minutes = (s == 0) ? 7'd10 : 7'd60;
      for (int h = 0; h <= 24; h++)
        for (int m = 0; m <= 60; m++) begin
          set_time(h, m);
          if (state == 2'd2) rang++;
        end
      checks++;
      if (rang !== 0) begin
        errors++; $display("FAIL invalid_setpoint%0d ring_cycles got=%0d want=0", s, rang);
      end
    end
  endtask

  task automatic test_enable_reset;
    set_time(7, 41);
    alarm_hours = 7'd7; alarm_minutes = 7'd42;
    set_time(7, 42);
    alarm_enable = 1'b0;
    step(1);
    checks++;
    if (state !== 2'd0 || ringing !== 1'b0 || blink !== 1'b0) begin
      errors++; $display("FAIL disable state=%0d ring=%b blink=%b want=0/0/0", state, ringing, blink);
    end
    alarm_enable = 1'b1;
    step(1);
    alarm_minutes = 7'd43;
    set_time(7, 43);
    press(1'b1, 1'b0);
    checks++;
    if (state !== 2'd3 || snooze_count !== 2'd1) begin
      errors++; $display("FAIL pre_reset state=%0d cnt=%0d want=3/1", state, snooze_count);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({state, ringing, blink, snooze_count} !== 6'b0) begin
      errors++; $display("FAIL async_reset got=%b want=000000", {state, ringing, blink, snooze_count});
    end
    step(1);
    reset_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_ring_blink();
    test_snooze();
    test_timeout();
    test_invalid();
    test_enable_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_unit.md
ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency.
REQ-002 SHALL have parameter BLINK_HZ, default 2, blink toggle rate while ringing.
REQ-003 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minute ticks.
REQ-004 SHALL have parameter RING_TIMEOUT_MIN, default 10, auto-stop after this many minute ticks of ringing.
REQ-005 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-006 SHALL use one clock, CLOCK_50, input, 1, rising-edge.
REQ-007 SHALL use reset_n, input, 1, reset that is asynchronous and active-low.
REQ-008 cur_minutes, input, 7, binary 0-59 from timekeeper out_minutes.
REQ-009 cur_hours, input, 7, binary 0-23 from timekeeper out_hours.
REQ-010 alarm_minutes / alarm_hours, input, 7 each, setpoint from CPU PIO.
REQ-011 alarm_enable, input, 1, level; 0 forces IDLE.
REQ-012 snooze_n / dismiss_n, input, 1 each, raw active-low KEY inputs, asynchronous.
REQ-013 ringing, output, 1, high in RINGING.
REQ-014 blink, output, 1, LED drive.
REQ-015 state, output, 2, IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-016 snooze_count, output, 2, snoozes used in current event.

Function
REQ-017 Keys SHALL pass a 2-flop synchroniser; a press is a one-cycle pulse on the synchronised 1->0 edge.
REQ-018 Minute tick SHALL be a one-cycle pulse when registered cur_minutes differs from its previous-cycle value.
REQ-019 alarm_valid SHALL be alarm_hours<=23 and alarm_minutes<=59; invalid setpoint never matches.
REQ-020 Match SHALL be minute tick AND alarm_valid AND cur == alarm (both fields); fires once per minute entry, including a time load landing exactly on the setpoint.
REQ-021 IDLE->ARMED when alarm_enable=1; any state->IDLE on the cycle after alarm_enable=0.
REQ-022 ARMED->RINGING on match; snooze_count cleared, ring-minute counter cleared.
REQ-023 RINGING->ARMED on dismiss press, or when ring-minute counter reaches RING_TIMEOUT_MIN.
REQ-024 RINGING->SNOOZE on snooze press when snooze_count<MAX_SNOOZE; snooze_count increments; otherwise the press is ignored.
REQ-025 Simultaneous snooze and dismiss presses: dismiss wins.
REQ-026 SNOOZE->RINGING when snooze-minute counter reaches SNOOZE_MIN; dismiss in SNOOZE ->ARMED.
REQ-027 Match while RINGING or SNOOZE SHALL be ignored.
REQ-028 blink SHALL toggle every CLK_HZ/(2*BLINK_HZ) cycles in RINGING, start at 1 on entry, be 0 in all other states.
REQ-029 State outputs SHALL be registered; ringing rises one cycle after the match cycle.
REQ-030 Minute counters SHALL saturate, never wrap.

Reset
REQ-031 On reset_n=0: state=IDLE, ringing=0, blink=0, snooze_count=0, all counters and synchroniser flops cleared, previous-minute register loaded with 0.
REQ-032 After reset release, first cycle SHALL NOT produce a minute tick (previous-minute register captures cur_minutes on first clock without tick).
REQ-033 Reset mid-ring SHALL stop ringing immediately (asynchronous).

Structure
REQ-034 Package alarm_pkg SHALL hold state encoding, 7-bit time width, hour/minute limits (23, 59).
REQ-035 Sub-module key_sync_edge (sync + falling-edge pulse) SHALL be instantiated twice.

Verification (CLK_HZ=8, BLINK_HZ=1, SNOOZE_MIN=2, RING_TIMEOUT_MIN=3, MAX_SNOOZE=3)
REQ-036 Enable, alarm 07:30, step cur 07:29->07:30 -> state ARMED->RINGING next cycle, blink 1,1,1,1,0,0,0,0 period.
REQ-037 Ringing, snooze press, 2 minute ticks -> SNOOZE then RINGING, snooze_count=1; fourth snooze press ignored.
REQ-038 Ringing, 3 minute ticks, no keys -> ARMED, ringing=0; simultaneous snooze+dismiss -> ARMED.
REQ-039 Alarm 24:10 or 07:60, sweep all times -> never RINGING.
REQ-040 alarm_enable=0 during RINGING -> IDLE next cycle; reset_n low mid-SNOOZE -> all outputs 0 asynchronously.
